// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared arbiter state, grant encodings and timeout default
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE_IF  = 2'd1,
        ST_SERVE_MEM = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - counts unacknowledged serve cycles and flags expiry
module wait_timer
    import mips_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Expiry fires in the cycle whose increment would reach TIMEOUT, so the
    // transaction spends exactly TIMEOUT serve cycles before being aborted.
    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and MEM-stage requests onto one memory port
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall_if,
    output logic              stall_pipe,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              bus_err
);

    arb_state_t state;
    arb_state_t next_state;
    grant_t     last_grant;

    logic if_elig;
    logic mem_elig;
    logic serving;
    logic expired;
    logic finish;
    logic enter_if;
    logic enter_mem;

    // A requester whose done pulse is high this cycle is already dropping its
    // request, which forces one bubble and naturally alternates under load.
    assign if_elig   = if_req & ~if_done;
    assign mem_elig  = mem_req & ~mem_done;
    assign serving   = (state != ST_IDLE);
    assign finish    = serving & (m_ack | expired);
    assign enter_if  = (state == ST_IDLE) && (next_state == ST_SERVE_IF);
    assign enter_mem = (state == ST_IDLE) && (next_state == ST_SERVE_MEM);

    assign stall_pipe = mem_req & ~mem_done;
    assign stall_if   = (if_req & ~if_done) | stall_pipe;

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (~serving),
        .enable (serving & ~m_ack),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_IF;
        end else begin
            state <= next_state;
            if (enter_if) begin
                last_grant <= GRANT_IF;
            end else if (enter_mem) begin
                last_grant <= GRANT_MEM;
            end
        end
    end

    always_comb begin
        next_state = state;
        m_req      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_elig && mem_elig) begin
                    next_state = (last_grant == GRANT_MEM) ? ST_SERVE_IF : ST_SERVE_MEM;
                end else if (mem_elig) begin
                    next_state = ST_SERVE_MEM;
                end else if (if_elig) begin
                    next_state = ST_SERVE_IF;
                end
            end
            ST_SERVE_IF, ST_SERVE_MEM: begin
                m_req = 1'b1;
                if (m_ack || expired) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Request side is captured once at grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (enter_if) begin
            m_we    <= 1'b0;
            m_addr  <= if_addr;
            m_wdata <= '0;
        end else if (enter_mem) begin
            m_we    <= mem_we;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_done  <= (state == ST_SERVE_IF) && finish;
            mem_done <= (state == ST_SERVE_MEM) && finish;
            if (serving && expired) begin
                bus_err <= 1'b1;
            end
            if ((state == ST_SERVE_IF) && finish) begin
                if_rdata <= m_ack ? m_rdata : '0;
            end
            if ((state == ST_SERVE_MEM) && finish) begin
                if (!m_ack) begin
                    mem_rdata <= '0;
                end else if (!m_we) begin
                    mem_rdata <= m_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stall_if;
    logic        stall_pipe;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .stall_if  (stall_if),
        .stall_pipe(stall_pipe),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; m_rdata = '0; m_ack = 1'b0;
        step();
        step();
        check("rst_m_req", m_req, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_dones", {if_done, mem_done}, 0);
        check("rst_rdata", if_rdata | mem_rdata, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_stalls", {stall_if, stall_pipe}, 0);
        rst = 1'b1;

        // single fetch, ack in third serve cycle
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        check("a_stall_if_req", stall_if, 1);
        check("a_m_req_idle", m_req, 0);
        step();
        check("a_m_req", m_req, 1);
        check("a_m_addr", m_addr, 32'h40);
        check("a_m_we", m_we, 0);
        step();
        check("a_stall_if_w1", stall_if, 1);
        step();
        check("a_stall_if_w2", stall_if, 1);
        m_ack = 1'b1; m_rdata = 32'h8C010004;
        step();
        m_ack = 1'b0;
        check("a_if_done", if_done, 1);
        check("a_if_rdata", if_rdata, 32'h8C010004);
        check("a_stall_if_done", stall_if, 0);
        check("a_m_req_after", m_req, 0);
        if_req = 1'b0;
        step();
        check("a_if_done_drop", if_done, 0);

        // simultaneous requests after reset: MEM first, IF after a bubble
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
        #1;
        check("b_stall_pipe", stall_pipe, 1);
        step();
        check("b_m_addr_mem", m_addr, 32'h100);
        check("b_m_we_mem", m_we, 0);
        check("b_stall_pipe_srv", stall_pipe, 1);
        m_ack = 1'b1; m_rdata = 32'h11112222;
        step();
        m_ack = 1'b0;
        check("b_mem_done", mem_done, 1);
        check("b_mem_rdata", mem_rdata, 32'h11112222);
        check("b_stall_pipe_done", stall_pipe, 0);
        check("b_bubble_m_req", m_req, 0);
        mem_req = 1'b0;
        step();
        check("b_m_req_if", m_req, 1);
        check("b_m_addr_if", m_addr, 32'h80);
        check("b_mem_done_drop", mem_done, 0);
        m_ack = 1'b1; m_rdata = 32'h33334444;
        step();
        m_ack = 1'b0;
        check("b_if_done", if_done, 1);
        check("b_if_rdata", if_rdata, 32'h33334444);
        if_req = 1'b0;
        step();

        // continuous contention: strict alternation starting with MEM
        if_req = 1'b1; if_addr = 32'hA0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'hB0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("c_grant_addr", m_addr, (i % 2 == 0) ? 32'hB0 : 32'hA0);
            m_ack = 1'b1; m_rdata = 32'h0C0C0000 + i;
            step();
            m_ack = 1'b0;
            check("c_done", {if_done, mem_done}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i == 5) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
        end
        step();
        check("c_idle", m_req, 0);
        check("c_if_rdata", if_rdata, 32'h0C0C0005);

        // store: request fields held, load data untouched
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
        step();
        check("d_m_we_1", m_we, 1);
        check("d_m_wdata_1", m_wdata, 32'hDEADBEEF);
        check("d_m_addr", m_addr, 32'h200);
        step();
        check("d_m_we_2", m_we, 1);
        check("d_m_wdata_2", m_wdata, 32'hDEADBEEF);
        m_ack = 1'b1; m_rdata = 32'h55555555;
        step();
        m_ack = 1'b0;
        check("d_mem_done", mem_done, 1);
        check("d_mem_rdata", mem_rdata, 32'h0C0C0004);
        mem_req = 1'b0; mem_we = 1'b0;
        step();

        // timeout after four serve cycles, then a good transaction
        if_req = 1'b1; if_addr = 32'h300;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("e_still_serving", m_req, 1);
        end
        check("e_no_err_yet", bus_err, 0);
        step();
        check("e_if_done", if_done, 1);
        check("e_if_rdata", if_rdata, 0);
        check("e_bus_err", bus_err, 1);
        check("e_m_req", m_req, 0);
        if_req = 1'b0;
        step();
        mem_req = 1'b1; mem_addr = 32'h400;
        step();
        m_ack = 1'b1; m_rdata = 32'h600DF00D;
        step();
        m_ack = 1'b0;
        check("e_good_done", mem_done, 1);
        check("e_good_rdata", mem_rdata, 32'h600DF00D);
        check("e_err_sticky", bus_err, 1);
        mem_req = 1'b0;
        step();

        // reset mid-transaction, late ack ignored
        mem_req = 1'b1; mem_addr = 32'h500;
        step();
        check("f_serving", m_req, 1);
        rst = 1'b0;
        step();
        mem_req = 1'b0;
        check("f_m_req", m_req, 0);
        check("f_m_addr", m_addr, 0);
        check("f_mem_done", mem_done, 0);
        check("f_bus_err", bus_err, 0);
        check("f_rdata", if_rdata | mem_rdata, 0);
        rst = 1'b1; m_ack = 1'b1; m_rdata = 32'h77;
        step();
        m_ack = 1'b0;
        check("f_late_ack_done", {if_done, mem_done}, 0);
        check("f_late_ack_m_req", m_req, 0);
        check("f_late_ack_rdata", mem_rdata, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all address ports.
REQ-002 Parameter DATA_W, default 32: data width of all data ports.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles spent waiting for m_ack before abort.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 if_req  in  1  instruction-fetch read request; held until if_done.
REQ-007 if_addr  in  ADDR_W  fetch address; stable while if_req is high.
REQ-008 if_rdata  out  DATA_W  fetched word, valid while if_done is high.
REQ-009 if_done  out  1  one-cycle completion pulse for the fetch requester.
REQ-010 mem_req / mem_we  in  1 each  MEM-stage request; write when mem_we=1, else load.
REQ-011 mem_addr / mem_wdata  in  ADDR_W / DATA_W  MEM-stage address and store data; stable while mem_req is high.
REQ-012 mem_rdata / mem_done  out  DATA_W / 1  load data and one-cycle completion pulse.
REQ-013 stall_if / stall_pipe  out  1 each  freeze PC+IF/ID, and freeze whole pipeline, respectively.
REQ-014 m_req, m_we, m_addr, m_wdata  out  1, 1, ADDR_W, DATA_W  single-port memory request side.
REQ-015 m_rdata, m_ack  in  DATA_W, 1  memory read data and one-cycle completion.
REQ-016 bus_err  out  1  sticky timeout flag.

Function
REQ-017 FSM states IDLE, SERVE_IF, SERVE_MEM; m_req SHALL be 1 exactly in SERVE_IF/SERVE_MEM.
REQ-018 IDLE: no eligible request -> IDLE; one eligible -> that SERVE state; both eligible -> winner per REQ-019.
REQ-019 Contention: MEM wins unless last_grant=MEM, then IF wins (strict alternation under continuous contention).
REQ-020 On entry to SERVE_x, m_addr/m_we/m_wdata SHALL be registered from requester x and held constant for the whole transaction; SERVE_IF forces m_we=0.
REQ-021 m_ack in SERVE_x -> next state IDLE; next cycle x_done=1 for exactly one cycle; x_rdata loaded with m_rdata on loads/fetches, unchanged on stores.
REQ-022 In the cycle x_done is high, request x SHALL be ineligible (requester drops req that cycle); minimum turnaround = 1 bubble cycle.
REQ-023 m_ack while in IDLE SHALL be ignored.
REQ-024 Wait counter: cleared on SERVE entry, increments each SERVE cycle without m_ack; reaching TIMEOUT -> IDLE, x_done pulsed, x_rdata=0, bus_err=1.
REQ-025 bus_err SHALL stay set until reset; arbitration continues normally after it.
REQ-026 stall_pipe = mem_req & ~mem_done (combinational).
REQ-027 stall_if = (if_req & ~if_done) | stall_pipe (combinational).
REQ-028 last_grant SHALL update on every SERVE entry.

Reset
REQ-029 While rst=0 at a clock edge: state=IDLE, last_grant=IF, counter=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, if_rdata=0, mem_rdata=0, if_done=0, mem_done=0, bus_err=0.
REQ-030 Reset mid-transaction SHALL abandon it with no done pulse; a late m_ack after reset is ignored per REQ-023.

Structure
REQ-031 FSM state encoding, grant encoding (IF/MEM) and default TIMEOUT SHALL live in the shared package mips_pkg.
REQ-032 The wait counter/timeout compare SHALL be a sub-module wait_timer (inputs clear, enable; output expired).

Verification
REQ-033 Single fetch: if_req=1, if_addr=0x40, m_ack after 3 cycles with m_rdata=0x8C010004 -> if_done one cycle later, if_rdata=0x8C010004, stall_if=1 until then.
REQ-034 Simultaneous if_req/mem_req load at 0x100 after reset -> SERVE_MEM first (m_addr=0x100), then SERVE_IF after one bubble; stall_pipe high until mem_done.
REQ-035 Both requesters held continuously for 6 transactions -> grant order MEM, IF, MEM, IF, MEM, IF.
REQ-036 Store mem_we=1, mem_wdata=0xDEADBEEF, m_ack at cycle 2 -> m_we=1 and m_wdata=0xDEADBEEF throughout, mem_done pulse, mem_rdata unchanged.
REQ-037 TIMEOUT=4, no m_ack -> after 4 SERVE cycles state IDLE, done pulse with rdata=0, bus_err=1 and stays 1 over later good transactions.
REQ-038 rst=0 during SERVE_MEM then m_ack next cycle -> m_req=0 after edge, no mem_done, all outputs at reset values.
